mux_n_to_1_reg: RTL
===================

Name: mux_n_to_1_reg

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer. Successor to the combinational 5-bit 2:1 select mux.
- Samples the select together with the data on a valid/ready handshake. Holds the chosen word in an output register backed by a one-entry skid buffer.
- Sits between a pipeline stage and its consumer. Typical use is register-destination or writeback-source selection, where the consumer can stall.

Parameters:
- WIDTH, 5, bit width of each data input and of out.
- NUM_IN, 4, number of data inputs (2..16).
- SEL_W, $clog2(NUM_IN) (minimum 1), select width. Derived; not overridden.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  concatenated inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  index of the input to pass; sampled only on accept.
- in_valid  input  1  in_data/sel valid this cycle.
- in_ready  output  1  block can accept this cycle (registered).
- out  output  WIDTH  selected word (registered).
- out_valid  output  1  out holds a valid word.
- out_ready  input  1  consumer takes out this cycle.
- sel_err  output  1  sticky out-of-range flag; present only with MUX_SEL_CHECK_EN.

Behaviour:
- Clocking and reset:
  - Single clock Clk. Reset Rst is synchronous and active-high.
  - On a Clk edge with Rst=1: out=0, out_valid=0, skid register=0, skid valid=0, in_ready=1, sel_err=0.
  - Rst overrides every other event in that cycle. In-flight or buffered words are discarded, with no partial output.
- Handshake events:
  - accept = in_valid & in_ready.
  - fire = out_valid & out_ready.
  - Data and sel are captured only on accept. in_data and sel are don't-care otherwise.
- Selected word:
  - sel < NUM_IN: in_data[sel*WIDTH +: WIDTH].
  - sel >= NUM_IN (possible when NUM_IN is not a power of two): all zeros.
- Latency: a word accepted at edge t appears on out with out_valid=1 after edge t, if the output register is free.
- States (from out_valid and skid valid):
  - EMPTY: no valid word; out_valid=0, in_ready=1.
  - ONE: output register valid, skid empty; in_ready=1.
  - TWO: output register and skid both valid; in_ready=0.
- Transitions:
  - EMPTY: accept -> ONE (out <= selected word). No accept -> stay EMPTY.
  - ONE, accept & fire -> ONE (out <= new word). Back-to-back throughput is 1 word/cycle.
  - ONE, accept & !fire -> TWO (skid <= new word, in_ready <= 0). out is unchanged.
  - ONE, !accept & fire -> EMPTY (out_valid <= 0). out keeps its last value.
  - ONE, neither -> hold.
  - TWO, fire -> ONE (out <= skid, skid valid <= 0, in_ready <= 1).
  - TWO, !fire -> hold. No accept is possible in TWO.
- Ordering and stability:
  - Words leave in acceptance order. None is dropped or duplicated.
  - out is stable while out_valid=1 and out_ready=0.
- in_ready depends only on registered state. There is no combinational path from out_ready to in_ready.

Optional Feature:
- Macro: MUX_SEL_CHECK_EN.
- Defined:
  - Adds output port sel_err (reset 0).
  - sel_err sets to 1 on the edge after any accept with sel >= NUM_IN, and stays 1 until Rst.
  - The datapath still passes zeros for that word.
- Undefined:
  - No sel_err port and no check logic.
  - Out-of-range select still yields zeros.

Test Plan:
- Reset, then Rst=0 idle -> out=0, out_valid=0, in_ready=1; holds for 5 cycles with in_valid=0.
- WIDTH=5, NUM_IN=4, in_data={5'h1F,5'h0A,5'h15,5'h03}, sel=2, single accept, out_ready=1 -> next cycle out=5'h0A, out_valid=1; following cycle out_valid=0.
- Streaming sel=0,1,2,3 on consecutive cycles, out_ready=1 -> out = 03,15,0A,1F on consecutive cycles; in_ready stays 1.
- out_ready=0, accept sel=1 then sel=3 -> out=5'h15 held, in_ready=0. Then out_ready=1 -> out=5'h1F next cycle, in_ready=1, in order.
- In state TWO, assert Rst for one cycle -> out_valid=0, out=0, in_ready=1. The buffered 5'h1F is never emitted.
- NUM_IN=3, MUX_SEL_CHECK_EN defined, accept sel=3 -> out=0, out_valid=1, sel_err=1. sel_err stays 1 after later valid selects until Rst.

Source files
------------

// File: rtl/mux_n_to_1_reg.sv
// Registered N:1 word multiplexer with a valid/ready handshake and a one-entry skid buffer.
// Optional out-of-range select flag (sel_err) is built when MUX_SEL_CHECK_EN is defined.
module mux_n_to_1_reg #(
    parameter  int WIDTH  = 5,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_SEL_CHECK_EN
    ,
    output logic                    sel_err
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] sel_word;
    logic             accept;
    logic             fire;
    logic             load_out;
    logic             load_skid;
    logic             from_skid;

    // Out-of-range selects match no input and leave the word at zero.
    always_comb begin
        sel_word = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k))
                sel_word = in_data[k*WIDTH +: WIDTH];
        end
    end

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out       = out_q;
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d  = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (fire) begin
                    state_d   = ONE;
                    load_out  = 1'b1;
                    from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_out)
                out_q <= from_skid ? skid_q : sel_word;
            if (load_skid)
                skid_q <= sel_word;
        end
    end

`ifdef MUX_SEL_CHECK_EN
    logic in_range;

    always_comb begin
        in_range = 1'b0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k))
                in_range = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            sel_err <= 1'b0;
        else if (accept && !in_range)
            sel_err <= 1'b1;
    end
`endif

endmodule
